spi_link_host: RTL
==================

SPI_LINK_HOST -- requirements
Module: spi_link_host

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, is the maximum number of bytes sent but not yet echoed (rx_valid) before tx stalls.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; accepted when both are high.
REQ-005 cmd_op  input  3  0=WR_DAC, 1=PACKET, 2=SD_WR, 3=SD_RD, 4=FIFO_RD, 5=FIFO_WR; 6 and 7 are illegal.
REQ-006 cmd_addr  input  7  SD register address (SD_WR, SD_RD only).
REQ-007 cmd_data  input  8  data byte (WR_DAC, SD_WR, FIFO_WR).
REQ-008 cmd_len  input  16  PACKET payload length minus one.
REQ-009 pl_data / pl_valid / pl_ready  input / input / output  8 / 1 / 1  PACKET payload stream.
REQ-010 tx_byte / tx_valid / tx_ready  output / output / input  8 / 1 / 1  byte stream to the SPI byte master.
REQ-011 rx_byte / rx_valid  input / input  8 / 1  one pulse per completed byte exchange, in tx order.
REQ-012 rsp_valid  output  1  one-cycle pulse at command completion.
REQ-013 rsp_data / rsp_err  output / output  8 / 1  read result / illegal-op flag.

Function
REQ-014 Byte sequences SHALL be: WR_DAC 87,data; PACKET 88,len[7:0],len[15:8],len+1 payload bytes; SD_WR 89,{1,addr},data; SD_RD 89,{0,addr},00; FIFO_RD 8A,00; FIFO_WR 8B,data.
REQ-015 States SHALL be IDLE, SEND_OP, SEND_ARG, SEND_PAYLOAD, DRAIN, DONE.
REQ-016 cmd_ready SHALL be high only in IDLE; on acceptance, cmd fields SHALL be latched and the FSM SHALL move to SEND_OP on the next cycle.
REQ-017 An illegal op SHALL send no bytes and SHALL go to DONE with rsp_err=1 and rsp_data=00.
REQ-018 A byte SHALL transfer on a cycle with tx_valid&&tx_ready; tx_byte SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-019 SEND_ARG SHALL send the remaining fixed bytes in order; PACKET SHALL then enter SEND_PAYLOAD; all other ops SHALL enter DRAIN.
REQ-020 In SEND_PAYLOAD, pl_ready SHALL equal tx_ready gated by the outstanding limit; tx_byte SHALL equal pl_data and tx_valid SHALL equal pl_valid (zero-latency pass-through).
REQ-021 A 17-bit payload counter SHALL count accepted payload bytes; after byte number cmd_len+1 (cmd_len=FFFF gives 65536 bytes), the FSM SHALL enter DRAIN.
REQ-022 An outstanding counter SHALL increment per transferred byte and decrement per rx_valid (net 0 when both occur in the same cycle); tx_valid and pl_ready SHALL be low while it equals MAX_OUTSTANDING.
REQ-023 For SD_RD and FIFO_RD, rx_byte SHALL be captured on the rx_valid matching the final 00 byte; other ops SHALL discard rx bytes.
REQ-024 DRAIN SHALL wait for the outstanding count to reach 0 and then move to DONE.
REQ-025 DONE SHALL assert rsp_valid for exactly one cycle and return to IDLE, giving minimum back-to-back spacing of one idle cycle.
REQ-026 rx_valid in IDLE SHALL be ignored and SHALL NOT underflow the counter.

Reset
REQ-027 During rst: state=IDLE; cmd_ready=0, tx_valid=0, pl_ready=0, rsp_valid=0, rsp_err=0, rsp_data=00, tx_byte=00; counters=0.
REQ-028 rst mid-command SHALL abort the command with no rsp_valid; cmd_ready SHALL go high the cycle after rst deasserts.

Structure
REQ-029 Shared package spi_link_pkg SHALL hold the opcode constants (87..8B), the HEADER_SIZE=2 constant, and the cmd_op enum, shared with the device-side decoder.
REQ-030 One sub-module SHALL be used: spi_link_outstanding_ctr (up/down counter with full flag).

Verification
REQ-031 WR_DAC, data=5A, tx_ready=1, echo after 2 cycles -> tx 87,5A; rsp_valid once, rsp_err=0.
REQ-032 SD_RD, addr=12, echo returns 00,00,C3 -> tx 89,12,00; rsp_data=C3.
REQ-033 PACKET, cmd_len=0003, payload 01..04 with pl_valid gaps -> tx 88,03,00,01,02,03,04; rsp after 7 echoes.
REQ-034 MAX_OUTSTANDING=4, echoes withheld -> exactly 4 bytes sent, tx_valid stays low until first rx_valid.
REQ-035 cmd_op=7 -> no tx bytes; rsp_err=1 and rsp_valid 2 cycles after acceptance.
REQ-036 rst asserted mid-payload of a PACKET with cmd_len=00FF -> tx_valid=0 next cycle, no rsp_valid; subsequent FIFO_RD completes with tx 8A,00.

Source files
------------

// File: rtl/spi_link_pkg.sv
// Definitions shared between the SPI link host and the device-side decoder.
// These cover the wire opcodes, the command encoding and small helpers that
// describe the fixed byte framing of each command.
package spi_link_pkg;

  // Bytes that follow the opcode in the longest fixed header (PACKET length, SD addr+data)
  localparam int HEADER_SIZE = 2;

  localparam logic [7:0] OPC_WR_DAC  = 8'h87;
  localparam logic [7:0] OPC_PACKET  = 8'h88;
  localparam logic [7:0] OPC_SD      = 8'h89;
  localparam logic [7:0] OPC_FIFO_RD = 8'h8A;
  localparam logic [7:0] OPC_FIFO_WR = 8'h8B;

  typedef enum logic [2:0] {
    CMD_WR_DAC  = 3'd0,
    CMD_PACKET  = 3'd1,
    CMD_SD_WR   = 3'd2,
    CMD_SD_RD   = 3'd3,
    CMD_FIFO_RD = 3'd4,
    CMD_FIFO_WR = 3'd5
  } cmd_op_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic op_is_read(input logic [2:0] op);
    return (op == CMD_SD_RD) || (op == CMD_FIFO_RD);
  endfunction

  // Ops whose fixed argument section is HEADER_SIZE bytes rather than one
  function automatic logic op_has_two_args(input logic [2:0] op);
    return (op == CMD_PACKET) || (op == CMD_SD_WR) || (op == CMD_SD_RD);
  endfunction

  function automatic logic [7:0] op_opcode(input logic [2:0] op);
    case (op)
      CMD_WR_DAC:           return OPC_WR_DAC;
      CMD_PACKET:           return OPC_PACKET;
      CMD_SD_WR, CMD_SD_RD: return OPC_SD;
      CMD_FIFO_RD:          return OPC_FIFO_RD;
      CMD_FIFO_WR:          return OPC_FIFO_WR;
      default:              return 8'h00;
    endcase
  endfunction

  // Index (in echo order) of the echo carrying read data: the trailing 00 byte
  function automatic logic [1:0] op_rx_final_idx(input logic [2:0] op);
    case (op)
      CMD_SD_RD:   return 2'(HEADER_SIZE);
      CMD_FIFO_RD: return 2'd1;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_link_outstanding_ctr.sv
// Up/down counter of bytes handed to the SPI byte master but not yet echoed.
// Decrements are ignored at zero so stray echoes cannot underflow it.
module spi_link_outstanding_ctr #(
  parameter int MAX_COUNT = 4,
  localparam int CNT_W = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [CNT_W-1:0] count;
  logic             inc_ok;
  logic             dec_ok;

  assign inc_ok = inc && !full;
  assign dec_ok = dec && !empty;
  assign full   = (count == CNT_W'(MAX_COUNT));
  assign empty  = (count == '0);

  // Net count update; simultaneous inc and dec cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + CNT_W'(1);
    end else if (!inc_ok && dec_ok) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_link_host.sv
// Host-side SPI link command engine. Turns one command into its byte
// sequence for the SPI byte master, streams PACKET payload straight through,
// limits bytes in flight, captures read data from the echoes and reports
// completion with a single-cycle response pulse.
module spi_link_host
  import spi_link_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err
);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_SEND_OP      = 3'd1;
  localparam logic [2:0] ST_SEND_ARG     = 3'd2;
  localparam logic [2:0] ST_SEND_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DRAIN        = 3'd4;
  localparam logic [2:0] ST_DONE         = 3'd5;

  logic [2:0]  state;
  logic [2:0]  op_q;
  logic [6:0]  addr_q;
  logic [7:0]  data_q;
  logic [15:0] len_q;
  logic        arg_idx;
  logic [16:0] pl_cnt;
  logic [1:0]  rx_idx;
  logic [7:0]  rsp_data_q;
  logic        rsp_err_q;

  logic        ctr_full;
  logic        ctr_empty;
  logic        accept;
  logic        xfer;
  logic        rx_take;
  logic        op_legal;
  logic        arg_last;
  logic        rx_final;
  logic [7:0]  arg_byte;
  logic        tx_valid_c;
  logic [7:0]  tx_byte_c;
  logic        pl_ready_c;

  assign accept   = cmd_valid && cmd_ready;
  assign xfer     = tx_valid && tx_ready;
  assign rx_take  = rx_valid && (state != ST_IDLE) && !rst;
  assign op_legal = op_is_legal(op_q);
  assign arg_last = op_has_two_args(op_q) ? arg_idx : 1'b1;
  assign rx_final = op_is_read(op_q) && (rx_idx == op_rx_final_idx(op_q));

  // Outputs are forced quiet while reset is held, whatever state is pending
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign tx_valid  = tx_valid_c && !rst;
  assign tx_byte   = rst ? 8'h00 : tx_byte_c;
  assign pl_ready  = pl_ready_c && !rst;
  assign rsp_valid = (state == ST_DONE) && !rst;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  spi_link_outstanding_ctr #(
    .MAX_COUNT(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk  (clk),
    .rst  (rst),
    .inc  (xfer),
    .dec  (rx_take),
    .full (ctr_full),
    .empty(ctr_empty)
  );

  // Fixed argument byte for the latched command at the current argument index
  always_comb begin
    arg_byte = 8'h00;
    case (op_q)
      CMD_WR_DAC, CMD_FIFO_WR: arg_byte = data_q;
      CMD_PACKET:              arg_byte = arg_idx ? len_q[15:8] : len_q[7:0];
      CMD_SD_WR:               arg_byte = arg_idx ? data_q : {1'b1, addr_q};
      CMD_SD_RD:               arg_byte = arg_idx ? 8'h00 : {1'b0, addr_q};
      default:                 arg_byte = 8'h00;
    endcase
  end

  // Byte-stream drive; the payload path is a zero-latency pass-through
  always_comb begin
    tx_valid_c = 1'b0;
    tx_byte_c  = 8'h00;
    pl_ready_c = 1'b0;
    case (state)
      ST_SEND_OP: begin
        tx_valid_c = op_legal && !ctr_full;
        tx_byte_c  = op_opcode(op_q);
      end
      ST_SEND_ARG: begin
        tx_valid_c = !ctr_full;
        tx_byte_c  = arg_byte;
      end
      ST_SEND_PAYLOAD: begin
        tx_valid_c = pl_valid && !ctr_full;
        tx_byte_c  = pl_data;
        pl_ready_c = tx_ready && !ctr_full;
      end
      default: begin
        tx_valid_c = 1'b0;
      end
    endcase
  end

  // Command field capture on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      addr_q <= cmd_addr;
      data_q <= cmd_data;
      len_q  <= cmd_len;
    end
  end

  // Command sequencing FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      arg_idx <= 1'b0;
      pl_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SEND_OP;
            arg_idx <= 1'b0;
            pl_cnt  <= '0;
          end
        end
        ST_SEND_OP: begin
          if (!op_legal) begin
            state <= ST_DONE;
          end else if (xfer) begin
            state <= ST_SEND_ARG;
          end
        end
        ST_SEND_ARG: begin
          if (xfer) begin
            if (arg_last) begin
              state <= (op_q == CMD_PACKET) ? ST_SEND_PAYLOAD : ST_DRAIN;
            end else begin
              arg_idx <= 1'b1;
            end
          end
        end
        ST_SEND_PAYLOAD: begin
          if (xfer) begin
            pl_cnt <= pl_cnt + 17'd1;
            if (pl_cnt == {1'b0, len_q}) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (ctr_empty) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Echo tracking and response capture; only the final echo of a read is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_idx     <= 2'd0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      rx_idx     <= 2'd0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= !op_is_legal(cmd_op);
    end else if (rx_take) begin
      if (rx_final) begin
        rsp_data_q <= rx_byte;
      end
      if (rx_idx != 2'd3) begin
        rx_idx <= rx_idx + 2'd1;
      end
    end
  end

endmodule
